axis_addr_gen: RTL

Next-generation AXI address-channel generator for the axis memory path, usable on either the read or the write address channel. It accepts one transfer descriptor (start address and length in stream elements) and issues a sequence of AXI bursts. Each burst is capped by a runtime-independent BURST_MAX and never crosses a 4 KB boundary. Every issued burst is also published on a burst-info channel, so the data-side packer/unpacker can generate or check last-beat markers.

---
 rtl/axis_addr_gen_pkg.sv | 29 ++
 rtl/axis_addr_split.sv | 31 +++
 rtl/axis_addr_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/axis_addr_gen_pkg.sv
// Shared constants and helpers for the axis AXI address generator.
package axis_addr_gen_pkg;

    localparam int unsigned IdleIdx  = 0;
    localparam int unsigned SetupIdx = 1;
    localparam int unsigned CalcIdx  = 2;
    localparam int unsigned IssueIdx = 3;
    localparam int unsigned DoneIdx  = 4;

    localparam int unsigned Boundary = 4096;

    typedef enum logic [4:0] {
        StIdle  = 5'(1 << IdleIdx),
        StSetup = 5'(1 << SetupIdx),
        StCalc  = 5'(1 << CalcIdx),
        StIssue = 5'(1 << IssueIdx),
        StDone  = 5'(1 << DoneIdx)
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_addr_split.sv
// Burst length for the next AXI burst: min(remaining, BURST_MAX, beats left in the 4 KB page).
module axis_addr_split
    import axis_addr_gen_pkg::*;
#(
    parameter int unsigned CONFIG_DWIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BURST_MAX      = 256
) (
    input  logic [CONFIG_DWIDTH:0]   remaining,
    input  logic [11:0]              addr_lo,
    output logic [AXI_LEN_WIDTH:0]   beats
);

    localparam int unsigned Bytes     = AXI_DATA_WIDTH / 8;
    localparam int unsigned ByteShift = clog2(Bytes);
    localparam int unsigned RW        = CONFIG_DWIDTH + 1;

    logic [12:0]   room_bytes;
    logic [RW-1:0] room_beats;
    logic [RW-1:0] cap;
    logic [RW-1:0] min_beats;

    // addr_lo is bus-aligned, so room_beats is exact and never zero.
    assign room_bytes = 13'(Boundary) - {1'b0, addr_lo};
    assign room_beats = RW'(room_bytes >> ByteShift);
    assign cap        = (room_beats < RW'(BURST_MAX)) ? room_beats : RW'(BURST_MAX);
    assign min_beats  = (remaining < cap) ? remaining : cap;
    assign beats      = min_beats[AXI_LEN_WIDTH:0];

endmodule

// File: rtl/axis_addr_gen.sv
// Splits one stream-element descriptor into 4 KB-safe AXI bursts and mirrors each on a burst-info channel.
module axis_addr_gen
    import axis_addr_gen_pkg::*;
#(
    parameter int unsigned CONFIG_DWIDTH  = 32,
    parameter int unsigned CONVERT_SHIFT  = 1,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BURST_MAX      = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      axi_aready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
    output logic                      axi_avalid,
    output logic [AXI_LEN_WIDTH-1:0]  bst_len,
    output logic                      bst_valid,
    input  logic                      bst_ready,
    output logic                      done
);

    localparam int unsigned Bytes     = AXI_DATA_WIDTH / 8;
    localparam int unsigned ByteShift = clog2(Bytes);
    localparam int unsigned RW        = CONFIG_DWIDTH + 1;
    localparam int unsigned ElemWords = 1 << CONVERT_SHIFT;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CONFIG_DWIDTH-1:0]  len_q, len_d;
    logic [RW-1:0]             rem_q, rem_d;
    logic [AXI_LEN_WIDTH-1:0]  alen_q, alen_d;

    logic [AXI_LEN_WIDTH:0]    split_beats;
    logic [AXI_LEN_WIDTH:0]    split_m1;
    logic [AXI_LEN_WIDTH:0]    issue_beats;
    logic                      handshake;

    axis_addr_split #(
        .CONFIG_DWIDTH  (CONFIG_DWIDTH),
        .AXI_LEN_WIDTH  (AXI_LEN_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .BURST_MAX      (BURST_MAX)
    ) u_split (
        .remaining (rem_q),
        .addr_lo   (addr_q[11:0]),
        .beats     (split_beats)
    );

    assign split_m1    = split_beats - 1'b1;
    assign issue_beats = {1'b0, alen_q} + 1'b1;

    // bst_ready gates avalid so every address handshake has a slot on the burst-info channel.
    assign cfg_ready  = (state_q == StIdle);
    assign axi_avalid = (state_q == StIssue) && bst_ready;
    assign axi_aaddr  = addr_q;
    assign axi_alen   = alen_q;
    assign handshake  = axi_avalid && axi_aready;
    assign bst_valid  = handshake;
    assign bst_len    = alen_q;
    assign done       = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rem_d   = rem_q;
        alen_d  = alen_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    addr_d  = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(Bytes - 1);
                    len_d   = cfg_length;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                rem_d   = ({1'b0, len_q} + RW'(ElemWords - 1)) >> CONVERT_SHIFT;
                state_d = StCalc;
            end
            StCalc: begin
                if (rem_q == '0) begin
                    state_d = StDone;
                end else begin
                    alen_d  = split_m1[AXI_LEN_WIDTH-1:0];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (handshake) begin
                    addr_d  = addr_q + (AXI_ADDR_WIDTH'(issue_beats) << ByteShift);
                    rem_d   = rem_q - RW'(issue_beats);
                    state_d = StCalc;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
        rem_q  <= rem_d;
        alen_q <= alen_d;
    end

endmodule
